sdm_bitstream_gen: RTL
======================

Name: sdm_bitstream_gen

Overview:
- First-order sigma-delta bitstream generator. It emits a 1-bit stream whose count of ones per window of WINDOW clocks equals a requested level.
- Transmit-side counterpart of the comparator majority/decimation filter. It drives the feedback/DAC pin that the filter-side logic samples with the same window length.
- Level updates arrive through a valid/ready handshake and take effect only on window boundaries.

Parameters:
- WINDOW, 100, clocks per window; must match the receive filter length; must be ≥2.
- CNT_W, 17, width of level and window counters; 2^CNT_W must exceed WINDOW.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run request
- level_in  in  CNT_W  requested ones-per-window
- level_valid  in  1  level_in is valid
- level_ready  out  1  pending slot free
- dac_out  out  1  registered bitstream
- window_start  out  1  one-cycle pulse coincident with the first bit of each window
- running  out  1  high in RUN state

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - dac_out=0, window_start=0, running=0, level_ready=1.
  - State IDLE; active level=0; pending slot empty; accumulator acc=0; win_cnt=0.
- Handshake:
  - A transfer occurs on a rising edge with level_valid & level_ready.
  - The value is saturated to WINDOW if level_in>WINDOW, then stored in the pending slot.
  - level_ready = pending slot empty.
  - One pending entry only. The producer must hold level_valid while ready=0.
- States:
  - IDLE:
    - dac_out=0, acc held at 0.
    - On enable=1: pending (if full) moves to active and the slot empties; win_cnt=0; go RUN.
  - RUN, each cycle:
    - acc_next = acc + active (width CNT_W+1).
    - If acc_next ≥ WINDOW: dac_out<=1, acc<=acc_next−WINDOW. Otherwise dac_out<=0, acc<=acc_next.
    - window_start<=(win_cnt==0).
    - win_cnt increments and wraps WINDOW−1→0.
  - Window boundary (win_cnt==WINDOW−1 in RUN):
    - If enable=0: go IDLE next cycle, with dac_out<=0 in that cycle.
    - Otherwise, if pending is full: pending→active, slot empties, level_ready rises next cycle.
- Latency: first bit of a run appears on dac_out the cycle after IDLE→RUN. dac_out is always one register stage after the decision.
- Invariant: acc returns to exactly 0 at every boundary. Each window therefore contains exactly `active` ones, spread as evenly as first-order quantisation allows (no two ones adjacent while active ≤ WINDOW/2).
- Boundary conditions:
  - Level 0: all zeros.
  - Level WINDOW: all ones.
  - enable deasserted mid-window: the current window completes, so no partial window is emitted.
  - enable re-asserted before the boundary: RUN continues uninterrupted.
  - Handshake accepted in the boundary cycle while the slot is empty: the value goes to pending and applies at the next boundary, not this one.
  - reset mid-window: immediate return to reset values next cycle; pending is discarded.

Optional Feature:
- Macro SDM_SAT_FLAG_EN.
- When defined: adds output sat_flag (1 bit, reset 0). It pulses high for one cycle, the cycle after an accepted transfer whose level_in exceeded WINDOW.
- When undefined: the port and its logic are absent. Saturation still occurs silently.

Decomposition:
- Package sdm_pkg:
  - default WINDOW and CNT_W constants
  - state enum {IDLE, RUN}
  - a function for the saturation clamp
- One natural sub-module, sdm_window_counter: win_cnt, wrap, boundary and window_start generation. Shared with the receive-side filter for window alignment.

Test Plan:
- Reset with enable=1 and pending empty → running=1; dac_out is 0 for the first 100 cycles (active=0); window_start pulses every 100 cycles.
- Load 30, enable → exactly 30 ones per 100-cycle window for 5 windows; no adjacent ones; acc=0 at each boundary.
- Load 100, then 0 → first window all ones, second window all zeros; transition exactly at the window_start pulse.
- Load 150 → 100 ones per window; with SDM_SAT_FLAG_EN, a single sat_flag pulse the cycle after acceptance.
- Two back-to-back valid levels (40, 60) mid-window:
  - First is accepted and level_ready drops.
  - Second stalls until the cycle after the boundary.
  - Windows emit 40 then 60 ones.
- Deassert enable at cycle 50 of a window with level 50 → window completes with 50 ones, then IDLE with dac_out=0. Separately, assert reset at cycle 50 → dac_out=0 and running=0 next cycle, pending cleared.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared constants, state encoding and level clamp for the sigma-delta bitstream generator.
package sdm_pkg;

    localparam int SDM_WINDOW_DEF = 100;
    localparam int SDM_CNT_W_DEF  = 17;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sdm_state_e;

    // Limits a requested level to the window length.
    function automatic logic [31:0] sdm_sat_clamp(input logic [31:0] level,
                                                  input logic [31:0] limit);
        logic [31:0] res;
        if (level > limit) begin
            res = limit;
        end else begin
            res = level;
        end
        return res;
    endfunction

endpackage

// File: rtl/sdm_window_counter.sv
// Window position counter: wraps every WINDOW clocks while running, flags the last
// position and emits a registered pulse aligned with the first bit of each window.
module sdm_window_counter
    import sdm_pkg::*;
#(
    parameter int WINDOW = SDM_WINDOW_DEF,
    parameter int CNT_W  = SDM_CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic boundary,
    output logic window_start
);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0] win_cnt_r;
    logic             window_start_r;

    assign boundary     = run & (win_cnt_r == LAST_C);
    assign window_start = window_start_r;

    // Position counter and start-of-window pulse; parked at zero outside RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt_r      <= {CNT_W{1'b0}};
            window_start_r <= 1'b0;
        end else if (run) begin
            if (win_cnt_r == LAST_C) begin
                win_cnt_r <= {CNT_W{1'b0}};
            end else begin
                win_cnt_r <= win_cnt_r + CNT_W'(1);
            end
            window_start_r <= (win_cnt_r == {CNT_W{1'b0}});
        end else begin
            win_cnt_r      <= {CNT_W{1'b0}};
            window_start_r <= 1'b0;
        end
    end

endmodule

// File: rtl/sdm_bitstream_gen.sv
// First-order sigma-delta bitstream generator: emits exactly `level` ones per WINDOW clocks.
// Optional macro SDM_SAT_FLAG_EN adds the sat_flag output for clamped level transfers.
module sdm_bitstream_gen
    import sdm_pkg::*;
#(
    parameter int WINDOW = SDM_WINDOW_DEF,
    parameter int CNT_W  = SDM_CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] level_in,
    input  logic             level_valid,
    output logic             level_ready,
    output logic             dac_out,
    output logic             window_start,
    output logic             running
`ifdef SDM_SAT_FLAG_EN
    ,
    output logic             sat_flag
`endif
);
    localparam logic [CNT_W:0] WIN_EXT = (CNT_W + 1)'(WINDOW);

    sdm_state_e       state_r, state_next_s;
    logic [CNT_W-1:0] active_r, active_next_s;
    logic [CNT_W-1:0] pend_r, pend_next_s;
    logic             pend_full_r, pend_full_next_s;
    logic [CNT_W-1:0] acc_r, acc_next_s;
    logic [CNT_W:0]   acc_sum_s;
    logic             dac_r, dac_next_s;
    logic             running_r;
    logic             xfer_s;
    logic             run_s;
    logic             boundary_s;

    assign run_s       = (state_r == RUN);
    assign xfer_s      = level_valid & ~pend_full_r;
    assign acc_sum_s   = {1'b0, acc_r} + {1'b0, active_r};
    assign level_ready = ~pend_full_r;
    assign dac_out     = dac_r;
    assign running     = running_r;

    sdm_window_counter #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) u_win (
        .clock        (clock),
        .reset        (reset),
        .run          (run_s),
        .boundary     (boundary_s),
        .window_start (window_start)
    );

    // Next-state, handshake slot, accumulator and bit decision.
    always_comb begin
        state_next_s     = state_r;
        active_next_s    = active_r;
        pend_next_s      = pend_r;
        pend_full_next_s = pend_full_r;
        acc_next_s       = acc_r;
        dac_next_s       = 1'b0;

        // The slot only accepts when empty, so it never collides with a promotion below.
        if (xfer_s) begin
            pend_next_s      = CNT_W'(sdm_sat_clamp(32'(level_in), 32'(WINDOW)));
            pend_full_next_s = 1'b1;
        end else begin
            pend_next_s      = pend_r;
        end

        case (state_r)
            IDLE: begin
                acc_next_s = {CNT_W{1'b0}};
                dac_next_s = 1'b0;
                if (enable) begin
                    state_next_s = RUN;
                    if (pend_full_r) begin
                        active_next_s    = pend_r;
                        pend_full_next_s = 1'b0;
                    end else begin
                        active_next_s = active_r;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (acc_sum_s >= WIN_EXT) begin
                    dac_next_s = 1'b1;
                    acc_next_s = CNT_W'(acc_sum_s - WIN_EXT);
                end else begin
                    dac_next_s = 1'b0;
                    acc_next_s = acc_sum_s[CNT_W-1:0];
                end
                // acc is back to zero here, so a new level starts a clean window.
                if (boundary_s) begin
                    if (!enable) begin
                        state_next_s = IDLE;
                    end else if (pend_full_r) begin
                        active_next_s    = pend_r;
                        pend_full_next_s = 1'b0;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
                acc_next_s   = {CNT_W{1'b0}};
                dac_next_s   = 1'b0;
            end
        endcase
    end

    // State, level and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            active_r    <= {CNT_W{1'b0}};
            pend_r      <= {CNT_W{1'b0}};
            pend_full_r <= 1'b0;
            acc_r       <= {CNT_W{1'b0}};
            dac_r       <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            active_r    <= active_next_s;
            pend_r      <= pend_next_s;
            pend_full_r <= pend_full_next_s;
            acc_r       <= acc_next_s;
            dac_r       <= dac_next_s;
            running_r   <= (state_next_s == RUN);
        end
    end

`ifdef SDM_SAT_FLAG_EN
    logic sat_flag_r;

    // One-cycle flag after a transfer whose level had to be clamped.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_flag_r <= 1'b0;
        end else begin
            sat_flag_r <= xfer_s & (32'(level_in) > 32'(WINDOW));
        end
    end

    assign sat_flag = sat_flag_r;
`endif

endmodule
